// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg -- shared definitions for the LC-3 style datapath blocks.
//
// Contents:
//   wb_sel_e   : write-back data source select (W_control encoding)
//   PSR_N/Z/P  : bit positions of the condition codes inside psr
//   REG_IDX_W  : width of a register index
// ---------------------------------------------------------------------------
package lc3_pkg;

    localparam int REG_IDX_W = 3;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_PC   = 2'd2,
        WB_SEL_NONE = 2'd3
    } wb_sel_e;

    // psr is ordered {N, Z, P}
    localparam int PSR_N = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_P = 0;

endpackage

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- general-purpose register file, one write port, two read ports.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   we_i                : write enable (commit on rising clk edge)
//   waddr_i, wdata_i    : write index / data
//   raddr1_i, raddr2_i  : read indices (combinational, independent)
//   rdata1_o, rdata2_o  : read data; a same-cycle write is not visible here
// ---------------------------------------------------------------------------
module reg_file
    import lc3_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [REG_IDX_W-1:0] raddr1_i,
    input  logic [REG_IDX_W-1:0] raddr2_i,
    output logic [DATA_W-1:0]    rdata1_o,
    output logic [DATA_W-1:0]    rdata2_o
);

    logic [DATA_W-1:0] regs_q [REG_CNT];

    // NOTE: this storage is deliberately reset -- architectural registers must
    // read as zero after reset, so it maps to flops rather than a RAM macro.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/writeback.sv
// ---------------------------------------------------------------------------
// writeback -- write-back stage: selects the commit data, writes the register
// file, maintains the {N,Z,P} condition codes and serves two read ports.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   enable_writeback         : commit strobe for the current instruction
//   W_control                : data source (ALU / MEM / PC / no write)
//   aluout, pcout, memout    : candidate write data
//   dr, sr1, sr2             : destination and read register indices
//   VSR1, VSR2               : read data for sr1 / sr2
//   psr                      : registered condition codes {N,Z,P}
//
// Configuration:
//   WB_BYPASS_EN (macro)     : when defined, a read port addressing dr during
//                              an enabled write returns the write data in the
//                              same cycle; otherwise it returns the old value.
// ---------------------------------------------------------------------------
module writeback
    import lc3_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_writeback,
    input  logic [1:0]           W_control,
    input  logic [DATA_W-1:0]    aluout,
    input  logic [DATA_W-1:0]    pcout,
    input  logic [DATA_W-1:0]    memout,
    input  logic [REG_IDX_W-1:0] dr,
    input  logic [REG_IDX_W-1:0] sr1,
    input  logic [REG_IDX_W-1:0] sr2,
    output logic [DATA_W-1:0]    VSR1,
    output logic [DATA_W-1:0]    VSR2,
    output logic [2:0]           psr
);

    wb_sel_e           sel;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [2:0]        psr_d;
    logic [2:0]        psr_q;

    assign sel   = wb_sel_e'(W_control);
    assign wr_en = enable_writeback && (sel != WB_SEL_NONE);

    // NOTE: every signal driven here gets a default first so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        wr_data = aluout;
        case (sel)
            WB_SEL_ALU: wr_data = aluout;
            WB_SEL_MEM: wr_data = memout;
            WB_SEL_PC:  wr_data = pcout;
            default:    wr_data = aluout;  // no write; value is don't-care
        endcase
    end

    // Condition codes follow the value being committed; exactly one bit set.
    always_comb begin
        psr_d = psr_q;
        if (wr_en) begin
            psr_d = '0;
            if (wr_data[DATA_W-1]) begin
                psr_d[PSR_N] = 1'b1;
            end else if (wr_data == '0) begin
                psr_d[PSR_Z] = 1'b1;
            end else begin
                psr_d[PSR_P] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psr_q <= 3'b000;
        end else begin
            psr_q <= psr_d;
        end
    end

    assign psr = psr_q;

    reg_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wr_en),
        .waddr_i  (dr),
        .wdata_i  (wr_data),
        .raddr1_i (sr1),
        .raddr2_i (sr2),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

`ifdef WB_BYPASS_EN
    assign VSR1 = (wr_en && (sr1 == dr)) ? wr_data : rf_rd1;
    assign VSR2 = (wr_en && (sr2 == dr)) ? wr_data : rf_rd2;
`else
    assign VSR1 = rf_rd1;
    assign VSR2 = rf_rd2;
`endif

endmodule

// File: tb/tb_writeback.sv
// ---------------------------------------------------------------------------
// tb_writeback -- self-checking bench for writeback. A plain array of eight
// register values plus a psr value serves as the reference; directed steps
// cover reset, source select, no-write, dual read and read-during-write, and
// a random phase exercises arbitrary commit/read traffic.
// ---------------------------------------------------------------------------
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_writeback;
    logic [1:0]  W_control;
    logic [15:0] aluout, pcout, memout;
    logic [2:0]  dr, sr1, sr2;
    logic [15:0] VSR1, VSR2;
    logic [2:0]  psr;

    logic [15:0] model [8];
    logic [2:0]  psr_m;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    writeback #(.DATA_W(16), .REG_CNT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_writeback (enable_writeback),
        .W_control        (W_control),
        .aluout           (aluout),
        .pcout            (pcout),
        .memout           (memout),
        .dr               (dr),
        .sr1              (sr1),
        .sr2              (sr2),
        .VSR1             (VSR1),
        .VSR2             (VSR2),
        .psr              (psr)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] nzp(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] a,
                                         input logic [15:0] m, input logic [15:0] p);
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return p;
        return a;
    endfunction

    // Drive one commit shortly after a rising edge, let it take effect on the
    // next edge, then retire it in the model.
    task automatic commit(input logic en, input logic [1:0] sel, input logic [2:0] d,
                          input logic [15:0] a, input logic [15:0] m, input logic [15:0] p);
        enable_writeback = en;
        W_control        = sel;
        dr               = d;
        aluout           = a;
        memout           = m;
        pcout            = p;
        @(posedge clk);
        if (en && sel != 2'd3) begin
            model[d] = pick(sel, a, m, p);
            psr_m    = nzp(model[d]);
        end
        #1;
        enable_writeback = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            logic [2:0] b;
            a   = 3'(i);
            b   = 3'(i + 3);
            sr1 = a;
            sr2 = b;
            #1;
            check({tag, "_vsr1"}, VSR1, model[a]);
            check({tag, "_vsr2"}, VSR2, model[b]);
        end
        check({tag, "_psr"}, {13'd0, psr}, {13'd0, psr_m});
    endtask

    initial begin
        logic [15:0] exp_rd;
        rst = 1'b1;
        enable_writeback = 1'b0;
        W_control = 2'd0;
        aluout = '0; pcout = '0; memout = '0;
        dr = '0; sr1 = '0; sr2 = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        psr_m = 3'b000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Source select on R2
        sr1 = 3'd2;
        commit(1'b1, 2'd0, 3'd2, 16'h0005, 16'h8000, 16'h0000);
        check("sel_alu_r2", VSR1, 16'h0005);
        check("sel_alu_psr", {13'd0, psr}, 16'h0001);
        commit(1'b1, 2'd1, 3'd2, 16'h0005, 16'h8000, 16'h0000);
        check("sel_mem_r2", VSR1, 16'h8000);
        check("sel_mem_psr", {13'd0, psr}, 16'h0004);
        commit(1'b1, 2'd2, 3'd2, 16'h0005, 16'h8000, 16'h0000);
        check("sel_pc_r2", VSR1, 16'h0000);
        check("sel_pc_psr", {13'd0, psr}, 16'h0002);

        // No-write cases
        commit(1'b1, 2'd0, 3'd5, 16'h7777, 16'h0000, 16'h0000);
        commit(1'b1, 2'd3, 3'd5, 16'h8001, 16'h8002, 16'h8003);
        commit(1'b0, 2'd0, 3'd5, 16'h9999, 16'h0000, 16'h0000);
        check_all("nowrite");
        sr1 = 3'd5;
        #1;
        check("nowrite_r5", VSR1, 16'h7777);
        check("nowrite_psr", {13'd0, psr}, 16'h0001);

        // Dual read
        commit(1'b1, 2'd0, 3'd1, 16'h00AA, 16'h0000, 16'h0000);
        commit(1'b1, 2'd1, 3'd7, 16'h0000, 16'hFF00, 16'h0000);
        sr1 = 3'd1; sr2 = 3'd7;
        #1;
        check("dual_vsr1", VSR1, 16'h00AA);
        check("dual_vsr2", VSR2, 16'hFF00);
        sr1 = 3'd7;
        #1;
        check("same_vsr1", VSR1, 16'hFF00);
        check("same_vsr2", VSR2, 16'hFF00);

        // Read during write
        commit(1'b1, 2'd0, 3'd4, 16'h0001, 16'h0000, 16'h0000);
        sr1 = 3'd4;
        enable_writeback = 1'b1; W_control = 2'd0; dr = 3'd4; aluout = 16'h0002;
        #1;
`ifdef WB_BYPASS_EN
        check("rdw_same_cycle", VSR1, 16'h0002);
`else
        check("rdw_same_cycle", VSR1, 16'h0001);
`endif
        @(posedge clk);
        model[4] = 16'h0002;
        psr_m    = 3'b001;
        #1;
        enable_writeback = 1'b0;
        check("rdw_next_cycle", VSR1, 16'h0002);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            logic        en;
            logic [1:0]  sel;
            logic [2:0]  d;
            logic [15:0] a, m, p, wv;
            en  = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom_range(0, 3));
            d   = 3'($urandom_range(0, 7));
            a   = 16'($urandom);
            m   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            p   = 16'($urandom);
            wv  = pick(sel, a, m, p);
            enable_writeback = en; W_control = sel; dr = d;
            aluout = a; memout = m; pcout = p;
            sr1 = 3'($urandom_range(0, 7));
            sr2 = ($urandom_range(0, 3) == 0) ? d : 3'($urandom_range(0, 7));
            #1;
            exp_rd = model[sr1];
`ifdef WB_BYPASS_EN
            if (en && sel != 2'd3 && sr1 == d) exp_rd = wv;
`endif
            check("rand_vsr1", VSR1, exp_rd);
            exp_rd = model[sr2];
`ifdef WB_BYPASS_EN
            if (en && sel != 2'd3 && sr2 == d) exp_rd = wv;
`endif
            check("rand_vsr2", VSR2, exp_rd);
            @(posedge clk);
            if (en && sel != 2'd3) begin
                model[d] = wv;
                psr_m    = nzp(wv);
            end
            #1;
            check("rand_psr", {13'd0, psr}, {13'd0, psr_m});
            if (n % 50 == 49) check_all("rand_sweep");
        end
        enable_writeback = 1'b0;

        // Asynchronous reset mid-cycle after writing R3
        commit(1'b1, 2'd0, 3'd3, 16'h1234, 16'h0000, 16'h0000);
        sr1 = 3'd3;
        #1;
        check("pre_rst_r3", VSR1, 16'h1234);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_r3", VSR1, 16'h0000);
        check("async_rst_psr", {13'd0, psr}, 16'h0000);
        for (int i = 0; i < 8; i++) model[i] = '0;
        psr_m = 3'b000;
        // A commit while reset is held must be dropped
        commit(1'b1, 2'd0, 3'd5, 16'h4321, 16'h0000, 16'h0000);
        model[5] = '0;
        psr_m    = 3'b000;
        check_all("during_rst");
        rst = 1'b0;
        commit(1'b1, 2'd1, 3'd6, 16'h0000, 16'h8765, 16'h0000);
        check_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register and data path width.
REQ-002 SHALL have parameter REG_CNT, default 8, meaning number of general-purpose registers (register index width 3).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: enable_writeback  input  1  commit strobe for the current instruction.
REQ-007 SHALL have port: W_control  input  2  write-data source select.
REQ-008 SHALL have port: aluout  input  DATA_W  ALU result.
REQ-009 SHALL have port: pcout  input  DATA_W  computed effective address.
REQ-010 SHALL have port: memout  input  DATA_W  load data.
REQ-011 SHALL have port: dr  input  3  destination register index.
REQ-012 SHALL have port: sr1  input  3  read port 1 index.
REQ-013 SHALL have port: sr2  input  3  read port 2 index.
REQ-014 SHALL have port: VSR1  output  DATA_W  read port 1 data.
REQ-015 SHALL have port: VSR2  output  DATA_W  read port 2 data.
REQ-016 SHALL have port: psr  output  3  condition codes {N,Z,P}, registered.

Function
REQ-017 SHALL decode W_control: 0 = aluout, 1 = memout, 2 = pcout, 3 = no write.
REQ-018 SHALL write the selected data to register dr on the rising clk edge when enable_writeback=1 and W_control!=3; latency one cycle.
REQ-019 SHALL leave all registers and psr unchanged when enable_writeback=0 or W_control=3.
REQ-020 SHALL update psr on every register write, in the same edge: N=data[DATA_W-1]; Z=(data==0); P otherwise; exactly one bit set.
REQ-021 SHALL read VSR1/VSR2 combinationally from the register file, indexed by sr1/sr2; both ports are independent and may address the same register.
REQ-022 SHALL, when a write to dr and a read of dr occur in the same cycle, return the old value on the read port (without WB_BYPASS_EN).
REQ-023 SHALL treat data wider than 16 bits only by parameter; no truncation or sign handling applied to written data.

Reset
REQ-024 SHALL asynchronously clear all REG_CNT registers to 0 on rst=1, independent of clk.
REQ-025 SHALL asynchronously clear psr to 3'b000 on rst=1.
REQ-026 SHALL drop any write coincident with rst=1; the first write takes effect on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL support macro WB_BYPASS_EN: when defined, a read port whose index equals dr while a write is enabled (REQ-018) SHALL return the write data combinationally in that cycle; when undefined, REQ-022 applies.

Structure
REQ-028 SHALL take the W_control encodings (WB_SEL_ALU, WB_SEL_MEM, WB_SEL_PC, WB_SEL_NONE) and the psr bit positions from shared package lc3_pkg.
REQ-029 SHALL place the register file storage plus two read ports and one write port in sub-module reg_file; the data mux, psr logic and bypass stay in writeback.

Verification
REQ-030 SHALL verify reset: assert rst mid-run after writing R3=16'h1234 -> R3 reads 0 immediately (before next clk edge), psr=3'b000.
REQ-031 SHALL verify source select: dr=2, W_control=0/1/2 with aluout=16'h0005, memout=16'h8000, pcout=16'h0000 on successive cycles -> R2 = 16'h0005/16'h8000/16'h0000, psr = 001/100/010.
REQ-032 SHALL verify no-write cases: W_control=3 with enable_writeback=1, and W_control=0 with enable_writeback=0 -> registers and psr unchanged.
REQ-033 SHALL verify dual read: R1=16'h00AA, R7=16'hFF00, sr1=1, sr2=7 -> VSR1=16'h00AA, VSR2=16'hFF00; sr1=sr2=7 -> both 16'hFF00.
REQ-034 SHALL verify read-during-write: R4=16'h0001, write 16'h0002 to R4 with sr1=4 -> VSR1=16'h0001 that cycle without WB_BYPASS_EN, 16'h0002 with it; 16'h0002 the next cycle in both builds.
